// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, ALUOp codes, FSM state and trap-cause encodings
// for the multi-cycle MIPS main control unit.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] TC_NONE    = 2'b00;
  localparam logic [1:0] TC_ILLEGAL = 2'b01;
  localparam logic [1:0] TC_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    K_RTYPE,
    K_LW,
    K_SW,
    K_BEQ,
    K_ADDI
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       illegal;
  } dec_t;

  function automatic logic op_legal(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI};
  endfunction

endpackage

// File: rtl/mc_control_fsm_opcode_decode.sv
// Combinational opcode decoder: latched opcode to static datapath
// controls, instruction class and an illegal flag.
module opcode_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op,
  output dec_t       dec
);

  always_comb begin
    dec      = '0;
    dec.kind = K_RTYPE;
    unique case (1'b1)
      (op == OP_RTYPE): begin
        dec.kind    = K_RTYPE;
        dec.reg_dst = 1'b1;
        dec.alu_op  = ALU_FUNCT;
      end
      (op == OP_LW): begin
        dec.kind       = K_LW;
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_op     = ALU_ADD;
      end
      (op == OP_SW): begin
        dec.kind    = K_SW;
        dec.alu_src = 1'b1;
        dec.alu_op  = ALU_ADD;
      end
      (op == OP_BEQ): begin
        dec.kind   = K_BEQ;
        dec.alu_op = ALU_SUB;
      end
      (op == OP_ADDI): begin
        dec.kind    = K_ADDI;
        dec.alu_src = 1'b1;
        dec.alu_op  = ALU_ADD;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control FSM with memory-ready timeout,
// retired-instruction counter and sticky trap.
module mc_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       OpCode,
  input  logic             mem_ready,
  output logic             RegDst,
  output logic             AluSrc,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic [1:0]       ALUOp,
  output logic             PCWrite,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       state_dbg
);

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state;
  logic [5:0] op_q;
  logic [7:0] wait_cnt;
  dec_t       dec;
  logic       active;

  opcode_decode u_dec (
    .op  (op_q),
    .dec (dec)
  );

  assign state_dbg = state;
  assign active    = state inside {S_EXEC, S_MEM, S_WB};

  // Strobes follow the state register so reset drops them at once;
  // sw retires in the MEM cycle that sees mem_ready.
  always_comb begin
    RegDst   = 1'b0;
    AluSrc   = 1'b0;
    MemtoReg = 1'b0;
    ALUOp    = ALU_ADD;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    PCWrite  = 1'b0;
    if (active) begin
      RegDst   = dec.reg_dst;
      AluSrc   = dec.alu_src;
      MemtoReg = dec.mem_to_reg;
      ALUOp    = dec.alu_op;
    end
    unique case (state)
      S_EXEC: begin
        if (dec.kind == K_BEQ && !dec.illegal) begin
          Branch  = 1'b1;
          PCWrite = 1'b1;
        end
      end
      S_MEM: begin
        MemRead  = (dec.kind == K_LW);
        MemWrite = (dec.kind == K_SW);
        PCWrite  = (dec.kind == K_SW) && mem_ready;
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_FETCH;
      op_q        <= '0;
      wait_cnt    <= '0;
      trap        <= 1'b0;
      trap_cause  <= TC_NONE;
      instr_count <= '0;
    end else begin
      if (PCWrite) instr_count <= instr_count + CNT_W'(1);
      unique case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          op_q <= OpCode;
          if (!op_legal(OpCode)) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= TC_ILLEGAL;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (dec.illegal) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= TC_ILLEGAL;
          end else if (dec.kind == K_BEQ) begin
            state <= S_FETCH;
          end else if (dec.kind == K_LW || dec.kind == K_SW) begin
            state    <= S_MEM;
            wait_cnt <= '0;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            state    <= (dec.kind == K_LW) ? S_WB : S_FETCH;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == TO_LAST) begin
              state      <= S_TRAP;
              trap       <= 1'b1;
              trap_cause <= TC_TIMEOUT;
            end
          end
        end
        S_WB:   state <= S_FETCH;
        S_TRAP: state <= S_TRAP;
        default: state <= S_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-instruction cycle traces
// built from the opcode rules, checked by an independent monitor.
module tb_mc_control_fsm;

  localparam int TO = 4;
  localparam int CW = 4;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] BAD  = 6'b111111;

  typedef struct packed {
    logic [2:0] st;
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic [1:0] aluop;
    logic       pcwrite;
    logic       trap;
    logic [1:0] cause;
    logic [3:0] cnt;
  } vec_t;

  typedef struct packed {
    vec_t e;
    vec_t m;
  } exp_t;

  typedef struct packed {
    logic [5:0] op;
    logic       rdy;
    exp_t       x;
  } drv_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    OpCode;
  logic          mem_ready;
  logic          RegDst, AluSrc, MemtoReg, RegWrite;
  logic          MemRead, MemWrite, Branch, PCWrite, trap;
  logic [1:0]    ALUOp, trap_cause;
  logic [CW-1:0] instr_count;
  logic [2:0]    state_dbg;

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .OpCode      (OpCode),
    .mem_ready   (mem_ready),
    .RegDst      (RegDst),
    .AluSrc      (AluSrc),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Branch      (Branch),
    .ALUOp       (ALUOp),
    .PCWrite     (PCWrite),
    .trap        (trap),
    .trap_cause  (trap_cause),
    .instr_count (instr_count),
    .state_dbg   (state_dbg)
  );

  exp_t sb[$];
  drv_t plan[$];
  int   checks = 0;
  int   errors = 0;
  int   retired = 0;
  int   trap_hold = 3;
  bit   trapped = 1'b0;

  function automatic vec_t base(input logic [2:0] st);
    vec_t e = '0;
    e.st  = st;
    e.cnt = 4'(retired % 16);
    return e;
  endfunction

  function automatic vec_t with_static(input vec_t e, input vec_t s);
    vec_t r = e;
    r.regdst   = s.regdst;
    r.alusrc   = s.alusrc;
    r.memtoreg = s.memtoreg;
    r.aluop    = s.aluop;
    return r;
  endfunction

  function automatic void add(input logic [5:0] op, input logic rdy,
                              input vec_t e, input vec_t m);
    drv_t d;
    d.op  = op;
    d.rdy = rdy;
    d.x.e = e;
    d.x.m = m;
    plan.push_back(d);
  endfunction

  function automatic void add_trap(input logic [1:0] cause);
    vec_t e;
    trapped = 1'b1;
    for (int i = 0; i < trap_hold; i++) begin
      e       = base(3'd7);
      e.trap  = 1'b1;
      e.cause = cause;
      add(6'($urandom), 1'($urandom), e, '1);
    end
  endfunction

  task automatic step(input drv_t d);
    OpCode    = d.op;
    mem_ready = d.rdy;
    sb.push_back(d.x);
    @(posedge clk);
    #1;
  endtask

  // w = number of MEM cycles with mem_ready low before it rises
  task automatic issue(input logic [5:0] op, input int w, input int limit);
    bit   is_r, is_lw, is_sw, is_beq, is_addi, legal;
    vec_t e, s, m;
    is_r    = (op == R);
    is_lw   = (op == LW);
    is_sw   = (op == SW);
    is_beq  = (op == BEQ);
    is_addi = (op == ADDI);
    legal   = is_r | is_lw | is_sw | is_beq | is_addi;
    plan.delete();
    m          = '1;
    s          = '0;
    s.regdst   = is_r;
    s.alusrc   = is_lw | is_sw | is_addi;
    s.memtoreg = is_lw;
    s.aluop    = is_r ? 2'b10 : (is_beq ? 2'b01 : 2'b00);
    if (is_sw | is_beq) begin
      m.regdst   = 1'b0;
      m.memtoreg = 1'b0;
    end
    add(6'($urandom), 1'($urandom), base(3'd0), '1);
    add(op, 1'($urandom), base(3'd1), '1);
    if (!legal) begin
      add_trap(2'b01);
    end else if (is_beq) begin
      e         = with_static(base(3'd2), s);
      e.branch  = 1'b1;
      e.pcwrite = 1'b1;
      add(6'($urandom), 1'($urandom), e, m);
      retired++;
    end else begin
      add(6'($urandom), 1'($urandom), with_static(base(3'd2), s), m);
      if (is_lw | is_sw) begin
        for (int i = 0; i < w && i < TO; i++) begin
          e          = with_static(base(3'd3), s);
          e.memread  = is_lw;
          e.memwrite = is_sw;
          add(6'($urandom), 1'b0, e, m);
        end
        if (w >= TO) begin
          add_trap(2'b10);
        end else begin
          e          = with_static(base(3'd3), s);
          e.memread  = is_lw;
          e.memwrite = is_sw;
          e.pcwrite  = is_sw;
          add(6'($urandom), 1'b1, e, m);
          if (is_sw) retired++;
        end
      end
      if (!trapped && !is_sw) begin
        e          = with_static(base(3'd4), s);
        e.regwrite = 1'b1;
        e.pcwrite  = 1'b1;
        add(6'($urandom), 1'($urandom), e, m);
        retired++;
      end
    end
    for (int i = 0; i < plan.size() && i < limit; i++) step(plan[i]);
  endtask

  // Reset is asserted mid-cycle so its effect must show before the next edge.
  task automatic do_reset();
    exp_t x;
    x.e       = '0;
    x.m       = '1;
    reset     = 1'b0;
    mem_ready = 1'b0;
    sb.push_back(x);
    @(posedge clk);
    #1;
    sb.push_back(x);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    retired = 0;
    trapped = 1'b0;
  endtask

  initial begin : monitor
    exp_t x;
    vec_t act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x            = sb.pop_front();
        act.st       = state_dbg;
        act.regdst   = RegDst;
        act.alusrc   = AluSrc;
        act.memtoreg = MemtoReg;
        act.regwrite = RegWrite;
        act.memread  = MemRead;
        act.memwrite = MemWrite;
        act.branch   = Branch;
        act.aluop    = ALUOp;
        act.pcwrite  = PCWrite;
        act.trap     = trap;
        act.cause    = trap_cause;
        act.cnt      = instr_count;
        checks++;
        if (((act ^ x.e) & x.m) != '0) begin
          errors++;
          $display("FAIL ctrl @%0t: got %h required %h mask %h",
                   $time, act, x.e, x.m);
        end
        checks++;
        if (int'(RegWrite) + int'(MemWrite) + int'(Branch) > 1) begin
          errors++;
          $display("FAIL onehot @%0t: got rw=%b mw=%b br=%b required at most one",
                   $time, RegWrite, MemWrite, Branch);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: time limit reached, %0d entries pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k;
    logic [5:0] op;
    reset     = 1'b0;
    OpCode    = '0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    issue(R, 0, 1000);
    issue(LW, 3, 1000);
    issue(BEQ, 0, 1000);
    trap_hold = 20;
    issue(SW, 99, 1000);
    do_reset();
    trap_hold = 5;
    issue(BAD, 0, 1000);
    do_reset();
    issue(SW, TO - 1, 1000);
    issue(LW, TO - 1, 1000);
    issue(ADDI, 0, 1000);
    do_reset();
    for (int i = 0; i < 16; i++) issue(BEQ, 0, 1000);
    checks++;
    if (instr_count !== 4'(retired % 16) || retired != 16) begin
      errors++;
      $display("FAIL wrap: got %0d required %0d", instr_count, retired % 16);
    end
    issue(LW, 10, 5);
    do_reset();
    trap_hold = 3;
    repeat (300) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1:    op = R;
        2, 3:    op = LW;
        4, 5:    op = SW;
        6, 7:    op = BEQ;
        8:       op = ADDI;
        default: op = 6'($urandom);
      endcase
      issue(op, $urandom_range(0, 5), 1000);
      if (trapped) do_reset();
    end
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle main control unit directly upstream of the MIPS datapath.
- Consumes the datapath's OpCode output and produces every datapath control input: RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch and ALUOp.
- Adds PCWrite so the PC advances once per instruction.
- Adds a data-memory ready handshake with timeout, a retired-instruction counter and a sticky trap state.

Parameters:
MEM_TIMEOUT, 16, max cycles spent in MEM waiting for mem_ready before trapping (1..255)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
OpCode  input  6  instruction bits [31:26] from datapath
mem_ready  input  1  data memory completed current read/write
RegDst  output  1  1 = write register from Instruction[15:11]
AluSrc  output  1  1 = ALU operand B from sign-extend
MemtoReg  output  1  1 = write-back data from memory
RegWrite  output  1  register file write enable (one-cycle pulse)
MemRead  output  1  data memory read strobe
MemWrite  output  1  data memory write strobe
Branch  output  1  branch qualify, ANDed with Zero in datapath
ALUOp  output  2  00 add, 01 subtract, 10 funct-decoded
PCWrite  output  1  PC update enable (one-cycle pulse per instruction)
trap  output  1  sticky: illegal opcode or memory timeout
trap_cause  output  2  00 none, 01 illegal opcode, 10 memory timeout
instr_count  output  CNT_W  retired instructions, wraps modulo 2^CNT_W
state_dbg  output  3  current state encoding

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FETCH; every control output 0; ALUOp=00.
  - trap=0, trap_cause=00, instr_count=0, wait counter=0.
  - Reset mid-instruction aborts it; no RegWrite/MemWrite/PCWrite is emitted on or after assertion.
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- FETCH -> DECODE unconditionally. All strobes are 0.
- DECODE:
  - OpCode is latched into op_q.
  - Legal opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000.
  - Illegal opcode -> TRAP with trap_cause=01.
- Static decode outputs:
  - Driven from op_q only, never combinationally from OpCode.
  - Valid from the cycle after DECODE through the end of the instruction; 0 in FETCH, DECODE and TRAP.
  - R: RegDst=1, AluSrc=0, MemtoReg=0, ALUOp=10.
  - lw: RegDst=0, AluSrc=1, MemtoReg=1, ALUOp=00.
  - sw: AluSrc=1, ALUOp=00.
  - beq: AluSrc=0, ALUOp=01.
  - addi: RegDst=0, AluSrc=1, MemtoReg=0, ALUOp=00.
- EXEC:
  - beq: Branch=1 and PCWrite=1 in this cycle, then -> FETCH.
  - lw/sw -> MEM.
  - R/addi -> WB.
- MEM:
  - MemRead (lw) or MemWrite (sw) held high every MEM cycle until mem_ready is sampled 1.
  - The wait counter increments each MEM cycle in which mem_ready=0.
  - mem_ready=1: lw -> WB. sw pulses PCWrite in that same cycle -> FETCH. Counter is cleared.
  - Counter reaching MEM_TIMEOUT with mem_ready still 0 -> TRAP with trap_cause=10, strobes dropped.
  - mem_ready=1 on the same cycle the timeout is reached counts as success; ready wins.
  - mem_ready is ignored outside MEM.
- WB: RegWrite=1 and PCWrite=1 for exactly one cycle, then -> FETCH.
- TRAP: absorbing until reset. All strobes 0; trap=1; trap_cause holds its value.
- instr_count:
  - Increments by 1 on every PCWrite cycle.
  - All-ones + 1 -> 0.
  - Does not increment on trap.
- Latency in cycles: beq 3; R/addi 4; sw 4+w; lw 5+w (w = mem_ready wait cycles).
- Invariant: at most one of RegWrite, MemWrite, Branch is high in any cycle.
- Invariant: PCWrite is high in exactly one cycle per retired instruction.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI;
  - ALUOp constants ALU_ADD, ALU_SUB, ALU_FUNCT;
  - state encodings;
  - trap_cause codes.
- One natural sub-module: opcode_decode, purely combinational. It maps op_q to the static decode outputs plus an illegal flag. The FSM, wait counter and instr_count stay in mc_control_fsm.

Test Plan:
- R-type: OpCode=000000 after reset release -> states 0,1,2,4. RegDst=1, ALUOp=10 in EXEC/WB. RegWrite and PCWrite both high only in WB. instr_count 0->1.
- lw with mem_ready delayed 3 cycles -> MemRead high for 4 MEM cycles, then WB with MemtoReg=1, RegWrite=1. Total 8 cycles. instr_count=1.
- beq: OpCode=000100 -> Branch=1, PCWrite=1, ALUOp=01 in cycle 3 only, then FETCH. RegWrite/MemWrite never high.
- sw with MEM_TIMEOUT=4 and mem_ready held 0:
  - MemWrite high for 4 cycles, then TRAP; trap=1, trap_cause=10, state_dbg=7.
  - Remains in TRAP with no strobes for 20 further cycles.
  - instr_count is unchanged.
- Illegal OpCode=111111 -> TRAP after DECODE with trap_cause=01. reset=0 mid-TRAP -> immediate return to state 0 with all outputs 0.
- Counter wrap with CNT_W=4: 16 back-to-back beq -> instr_count returns to 0 after the 16th PCWrite. Reset asserted during an lw MEM wait -> MemRead drops asynchronously and no RegWrite occurs.
